// File: rtl/bus_pkg.sv
// Shared definitions for the bus-source selector: mode encodings, output
// register state and one-hot helpers sized for up to MAX_N channels.
package bus_pkg;

  localparam int unsigned MODE_SELECT = 0;
  localparam int unsigned MODE_RR     = 1;

  localparam int unsigned MAX_N = 64;
  localparam int unsigned IDX_W = $clog2(MAX_N);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  function automatic logic is_onehot(input logic [MAX_N-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_N'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_select_mux_if.sv
// Handshake bundle between N bus sources, the selector and the bus consumer.
interface stream_select_mux_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  logic [N-1:0]         in_valid;
  logic [N*W-1:0]       in_data;
  logic [N-1:0]         in_ready;
  logic [N-1:0]         sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic [$clog2(N)-1:0] out_src;
  logic                 sel_err;

  // slave: the selector itself
  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, out_src, sel_err
  );

  // master: sources and consumer around the selector
  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, out_src, sel_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// scanning upward and wrapping from N-1 to 0.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int unsigned   pos;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_select_mux.sv
// Registered N-channel selector feeding the shared bus; one output word
// buffered, with external one-hot select or internal round-robin choice.
module stream_select_mux
  import bus_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = MODE_SELECT
) (
  input logic               clk,
  input logic               rst_n,
  stream_select_mux_if.slave bus
);

  localparam int unsigned SW = $clog2(N);

  out_state_t    state;
  logic [W-1:0]  data_q;
  logic [SW-1:0] src_q;
  logic          sel_err_q;

  logic [N-1:0]  grant;
  logic          load;
  logic          xfer;
  logic [W-1:0]  xfer_data;
  logic [SW-1:0] xfer_src;

  assign load = (state == OUT_EMPTY) | bus.out_ready;
  assign xfer = |(bus.in_valid & grant) & load;

  always_comb begin
    xfer_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) xfer_data = bus.in_data[i*W +: W];
    end
  end

  assign xfer_src = SW'(onehot_to_idx(MAX_N'(grant)));

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SW-1:0] ptr;

      rr_arbiter #(.N(N)) u_arb (
        .req   (bus.in_valid),
        .ptr   (ptr),
        .grant (grant)
      );

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ptr <= '0;
        end else if (xfer) begin
          ptr <= (xfer_src == SW'(N-1)) ? '0 : SW'(xfer_src + SW'(1));
        end
      end

      assign sel_err_q = 1'b0;
    end else begin : g_sel
      logic sel_legal;
      logic sel_multi;

      assign sel_legal = is_onehot(MAX_N'(bus.sel));
      assign sel_multi = (bus.sel != '0) & ~sel_legal;
      assign grant     = sel_legal ? bus.sel : '0;

      always_ff @(posedge clk) begin
        if (!rst_n) sel_err_q <= 1'b0;
        else        sel_err_q <= sel_multi;
      end
    end
  endgenerate

  // A transfer and a consume in the same cycle simply reload: no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= OUT_EMPTY;
      data_q <= '0;
      src_q  <= '0;
    end else if (xfer) begin
      state  <= OUT_FULL;
      data_q <= xfer_data;
      src_q  <= xfer_src;
    end else if (bus.out_ready) begin
      state  <= OUT_EMPTY;
    end
  end

  assign bus.in_ready  = {N{load}} & grant;
  assign bus.out_valid = (state == OUT_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.sel_err   = sel_err_q;

endmodule
